// File: rtl/seg_value_formatter.sv
// Formats a CPU-written 16-bit value as four display digits for the seven-segment
// scanner. Hex mode passes nibbles through; decimal mode runs a double-dabble conversion.
module seg_value_formatter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_DEC   = 9999,
  parameter logic [3:0]  OVF_DIGIT = 4'hE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              hex_mode,
  output logic              busy,
  output logic [3:0]        digit0,
  output logic [3:0]        digit1,
  output logic [3:0]        digit2,
  output logic [3:0]        digit3,
  output logic              overflow,
  output logic              wr_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int unsigned ITER = DATA_W;

  state_t              state, state_nxt;
  logic                start_q;
  logic [DATA_W-1:0]   data_q;
  logic                hex_q;
  logic [DATA_W-1:0]   sreg;
  logic [15:0]         bcd;
  logic [15:0]         bcd_adj;
  logic [3:0]          cnt;
  logic                mode_hex;
  logic                ovf_sel;
  logic                in_range;
  logic                take;

  assign busy     = (state != IDLE);
  assign in_range = (data_q <= DATA_W'(MAX_DEC));
  // The write strobe is staged one edge before the FSM acts on it; a strobe seen
  // while busy (or while one is already staged) is dropped, never queued.
  assign take     = start && (state == IDLE) && !start_q;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_q) state_nxt = (hex_q || !in_range) ? DONE : SHIFT;
      SHIFT:   if (cnt == 4'(ITER - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 1'b0;
      data_q   <= '0;
      hex_q    <= 1'b0;
      sreg     <= '0;
      bcd      <= '0;
      cnt      <= '0;
      mode_hex <= 1'b0;
      ovf_sel  <= 1'b0;
      digit0   <= '0;
      digit1   <= '0;
      digit2   <= '0;
      digit3   <= '0;
      overflow <= 1'b0;
      wr_out   <= 1'b0;
    end else begin
      start_q <= take;
      if (take) begin
        data_q <= data_in;
        hex_q  <= hex_mode;
      end
      wr_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_q) begin
            sreg     <= data_q;
            mode_hex <= hex_q;
            ovf_sel  <= !hex_q && !in_range;
            bcd      <= '0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          {bcd, sreg} <= {bcd_adj, sreg} << 1;
          cnt         <= cnt + 4'd1;
        end
        DONE: begin
          wr_out <= 1'b1;
          if (ovf_sel) begin
            {digit3, digit2, digit1, digit0} <= {4{OVF_DIGIT}};
            overflow <= 1'b1;
          end else if (mode_hex) begin
            {digit3, digit2, digit1, digit0} <= sreg[15:0];
            overflow <= 1'b0;
          end else begin
            {digit3, digit2, digit1, digit0} <= bcd;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_value_formatter.sv
// Self-checking bench for seg_value_formatter: directed boundary cases plus random
// conversions compared against an arithmetic digit model.
module tb_seg_value_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        hex_mode;
  logic        busy;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic        overflow;
  logic        wr_out;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_dig;
  logic        exp_ovf;

  seg_value_formatter #(.DATA_W(16), .MAX_DEC(9999), .OVF_DIGIT(4'hE)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .hex_mode(hex_mode),
    .busy(busy), .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .overflow(overflow), .wr_out(wr_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected display {ovf, d3, d2, d1, d0} from plain arithmetic.
  function automatic logic [16:0] model(input logic [15:0] v, input logic hex);
    int unsigned x;
    x = v;
    if (hex) return {1'b0, v};
    if (x > 9999) return {1'b1, 16'hEEEE};
    return {1'b0, 4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // One conversion; inj_at >= 0 raises a stray start after that many edges past the accept.
  task automatic run_conv(input logic [15:0] v, input logic hex, input int inj_at, input bit tail);
    logic [16:0] m;
    int n, busy_cnt, lat;
    bit got;
    m   = model(v, hex);
    lat = (hex || v > 16'd9999) ? 2 : 18;
    data_in  = v;
    hex_mode = hex;
    start    = 1'b1;
    step();
    start    = 1'b0;
    data_in  = 16'($urandom);
    hex_mode = 1'($urandom);
    n = 0; got = 0; busy_cnt = 0;
    while (!got && n < 40) begin
      if (n == inj_at) begin
        start = 1'b1; data_in = 16'h0005; hex_mode = 1'b1;
      end
      step();
      start = 1'b0;
      n++;
      if (wr_out) got = 1;
      else begin
        if (busy) busy_cnt++;
        check("hold", {15'd0, overflow, digit3, digit2, digit1, digit0}, {15'd0, exp_ovf, exp_dig});
      end
    end
    check("wr_latency", n, lat);
    check("busy_len", busy_cnt, lat - 1);
    check("busy_end", busy, 0);
    check("digits", {digit3, digit2, digit1, digit0}, m[15:0]);
    check("overflow", overflow, m[16]);
    exp_dig = m[15:0];
    exp_ovf = m[16];
    if (tail) begin
      step();
      check("wr_single", wr_out, 0);
    end
  endtask

  initial begin
    bit seen;
    logic [15:0] v;
    logic h;
    rst = 1'b1; start = 1'b0; data_in = '0; hex_mode = 1'b0;
    exp_dig = '0; exp_ovf = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_wr", wr_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_digits", {digit3, digit2, digit1, digit0}, 0);
    rst = 1'b0;
    step();

    run_conv(16'hBEEF, 1'b1, -1, 1);
    run_conv(16'd1234, 1'b0, -1, 1);
    run_conv(16'd0, 1'b0, -1, 1);
    run_conv(16'd9999, 1'b0, -1, 1);
    run_conv(16'd10000, 1'b0, -1, 1);
    run_conv(16'hFFFF, 1'b0, -1, 1);

    // stray start at cnt=5 must not disturb the result or add a pulse
    run_conv(16'd4321, 1'b0, 6, 1);
    seen = 0;
    repeat (25) begin
      step();
      if (wr_out) seen = 1;
    end
    check("no_extra_wr", seen, 0);

    // reset at cnt=8 aborts the conversion
    data_in = 16'd4321; hex_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_wr", wr_out, 0);
    check("abort_digits", {digit3, digit2, digit1, digit0}, 0);
    check("abort_ovf", overflow, 0);
    exp_dig = '0; exp_ovf = 1'b0;
    seen = 0;
    repeat (25) begin
      step();
      if (wr_out) seen = 1;
    end
    check("abort_no_wr", seen, 0);
    run_conv(16'd8765, 1'b0, -1, 1);

    // back-to-back: second start lands in the wr_out cycle
    run_conv(16'd2468, 1'b0, -1, 0);
    run_conv(16'h1A2B, 1'b1, -1, 0);
    run_conv(16'd0507, 1'b0, -1, 1);

    for (int i = 0; i < 16; i++) begin
      h = 1'($urandom);
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
      run_conv(v, h, -1, (i % 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
